// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the CPU JTAG debug bridge: synchronises update-DR/IR strobes,
// queues each scanned command and issues one-hot per-channel action pulses on pop.
module jtag_debug_cmd_sync #(
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SR_W        = 38,
    parameter int unsigned ACT_BIT     = 35,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned NCH        = 1 << IR_W,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned LVL_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vs_udr,
    input  logic             vs_uir,
    input  logic [IR_W-1:0]  ir_in,
    input  logic [SR_W-1:0]  sr,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [IR_W-1:0]  cmd_ir,
    output logic [SR_W-1:0]  cmd_jdo,
    output logic             cmd_act,
    output logic [NCH-1:0]   take_action,
    output logic [NCH-1:0]   take_no_action,
    output logic             uir_pulse,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic [LVL_W-1:0] fifo_level
);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] jdo;
        logic            act;
    } cmd_t;

    localparam logic [LVL_W-1:0] FullLvl = LVL_W'(DEPTH);

    // Synchronisers and edge-detect history reset high so a strobe already
    // asserted at reset release is not mistaken for a new rising edge.
    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_hist_q, uir_hist_q;
    logic                   udr_rise, uir_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '1;
            uir_sync_q <= '1;
            udr_hist_q <= 1'b1;
            uir_hist_q <= 1'b1;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
            uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
        end
    end

    assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
    assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

    // Command FIFO state
    cmd_t             mem_q [DEPTH];
    cmd_t             head;
    cmd_t             push_cmd;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             not_empty, full, pop, push_ok, ovf_set;

    logic [NCH-1:0]   take_action_q, take_action_d;
    logic [NCH-1:0]   take_no_action_q, take_no_action_d;
    logic             uir_pulse_q;
    logic             overflow_q, overflow_d;

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (level_q != '0);
    assign full      = (level_q == FullLvl);
    assign pop       = not_empty & cmd_ready;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign push_ok   = udr_rise & (~full | pop);
    assign ovf_set   = udr_rise & full & ~pop;

    always_comb begin
        push_cmd.ir  = ir_in;
        push_cmd.jdo = sr;
        push_cmd.act = sr[ACT_BIT];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        take_action_d    = '0;
        take_no_action_d = '0;
        if (pop) begin
            take_action_d[head.ir]    = head.act;
            take_no_action_d[head.ir] = ~head.act;
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    assign overflow_d = ovf_set | (overflow_q & ~overflow_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            uir_pulse_q      <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            uir_pulse_q      <= uir_rise;
            overflow_q       <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible through the level count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    assign cmd_valid      = not_empty;
    assign cmd_ir         = not_empty ? head.ir  : '0;
    assign cmd_jdo        = not_empty ? head.jdo : '0;
    assign cmd_act        = not_empty & head.act;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign uir_pulse      = uir_pulse_q;
    assign overflow       = overflow_q;
    assign fifo_level     = level_q;

`ifndef SYNTHESIS
    level_bound_a: assert property (@(posedge clk) disable iff (!reset_n)
        level_q <= FullLvl);
    pulse_onehot_a: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({take_action_q, take_no_action_q}));
`endif

endmodule
